dm_wb_line_cache: RTL

//  Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and word-wide main memory.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/cache_line_store.sv | 52 +++++
 rtl/dm_wb_line_cache.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back line cache.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_REFILL,
        S_FILL_DONE
    } cache_state_t;

    localparam int unsigned WORD_BYTES = 4;

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines,
                                          input int unsigned line_words);
        return addr_w - idx_w(lines) - off_w(line_words);
    endfunction

    // A one-word line still needs a 1-bit counter/select to keep vectors legal.
    function automatic int unsigned word_w(input int unsigned line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data arrays: one combinational read port, one write port; valid/dirty clear on reset.
module cache_line_store #(
    parameter int unsigned LINES      = 2048,
    parameter int unsigned LINE_WORDS = 1,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 19,
    parameter int unsigned IDX_W      = 11,
    parameter int unsigned WORD_W     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WORD_W-1:0] rd_word,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [DATA_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic              wr_data_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_meta_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_dirty
);

    logic [DATA_W-1:0] data_mem [LINES][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_data  = data_mem[rd_idx][rd_word];

    always_ff @(posedge clk) begin
        if (wr_data_en) data_mem[wr_idx][wr_word] <= wr_data;
        if (wr_meta_en) tag_mem[wr_idx] <= wr_tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_meta_en) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= wr_dirty;
        end
    end

endmodule

// File: rtl/dm_wb_line_cache.sv
// Direct-mapped write-back write-allocate data cache with req/ack word memory port.
// Define CACHE_STATS_EN to add saturating hit/miss/write-back counters.
module dm_wb_line_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINES      = 2048,
    parameter int unsigned LINE_WORDS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbacks
`endif
);

    localparam int unsigned OFF_W  = off_w(LINE_WORDS);
    localparam int unsigned IDX_W  = idx_w(LINES);
    localparam int unsigned TAG_W  = tag_w(ADDR_W, LINES, LINE_WORDS);
    localparam int unsigned WORD_W = word_w(LINE_WORDS);

    cache_state_t state, state_next;

    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic [WORD_W-1:0] word_cnt;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic              last_word;
    logic              hit;

    logic [WORD_W-1:0] rd_word;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              rd_dirty;
    logic [DATA_W-1:0] rd_data;
    logic              wr_data_en;
    logic [WORD_W-1:0] wr_word;
    logic [DATA_W-1:0] wr_data;
    logic              wr_meta_en;
    logic [TAG_W-1:0]  wr_tag;
    logic              wr_dirty;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                   input logic [IDX_W-1:0] i,
                                                   input logic [WORD_W-1:0] w);
        return (ADDR_W'(t) << (IDX_W + OFF_W)) | (ADDR_W'(i) << OFF_W) | (ADDR_W'(w) << 2);
    endfunction

    assign req_tag   = TAG_W'(req_addr >> (IDX_W + OFF_W));
    assign req_idx   = IDX_W'(req_addr >> OFF_W);
    assign req_word  = WORD_W'((req_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign last_word = (word_cnt == WORD_W'(LINE_WORDS - 1));
    assign hit       = rd_valid && (rd_tag == req_tag);
    // Write-back streams the victim out of the array, so the read port follows the burst counter.
    assign rd_word   = (state == S_WB) ? word_cnt : req_word;
    assign cpu_rdata = (cpu_ready && !req_we) ? rd_data : rdata_q;

    cache_line_store #(
        .LINES     (LINES),
        .LINE_WORDS(LINE_WORDS),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W),
        .WORD_W    (WORD_W)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (req_idx),
        .rd_word   (rd_word),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_data   (rd_data),
        .wr_idx    (req_idx),
        .wr_word   (wr_word),
        .wr_data_en(wr_data_en),
        .wr_data   (wr_data),
        .wr_meta_en(wr_meta_en),
        .wr_tag    (wr_tag),
        .wr_dirty  (wr_dirty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            word_cnt  <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && cpu_req) begin
                req_addr  <= cpu_addr;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
            end
            if (state == S_LOOKUP) begin
                word_cnt <= '0;
            end else if ((state == S_WB || state == S_REFILL) && mem_ack) begin
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            end
            if (cpu_ready && !req_we) rdata_q <= rd_data;
        end
    end

    always_comb begin
        state_next = state;
        cpu_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_data_en = 1'b0;
        wr_word    = req_word;
        wr_data    = req_wdata;
        wr_meta_en = 1'b0;
        wr_tag     = req_tag;
        wr_dirty   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    cpu_ready  = 1'b1;
                    state_next = S_IDLE;
                    if (req_we) begin
                        wr_data_en = 1'b1;
                        wr_meta_en = 1'b1;
                        wr_dirty   = 1'b1;
                    end
                end else if (rd_valid && rd_dirty) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_REFILL;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_addr(rd_tag, req_idx, word_cnt);
                mem_wdata = rd_data;
                if (mem_ack && last_word) state_next = S_REFILL;
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = line_addr(req_tag, req_idx, word_cnt);
                if (mem_ack) begin
                    wr_data_en = 1'b1;
                    wr_word    = word_cnt;
                    wr_data    = mem_rdata;
                    if (last_word) state_next = S_FILL_DONE;
                end
            end
            S_FILL_DONE: begin
                cpu_ready  = 1'b1;
                wr_meta_en = 1'b1;
                wr_dirty   = req_we;
                wr_data_en = req_we;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbacks <= '0;
        end else if (state == S_LOOKUP) begin
            if (hit) begin
                if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
            end else begin
                if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
                if (rd_valid && rd_dirty && stat_wbacks != '1) stat_wbacks <= stat_wbacks + 32'd1;
            end
        end
    end
`endif

endmodule
